cve2_sleep_ctrl: RTL and testbench

Multi-domain successor of the core sleep unit: generates `NumDomains` independently gated clocks from one free-running clock, each domain with its own busy/wake/force-on inputs and a programmable idle-hysteresis window before gating. Fetch enable is made sticky, and no domain clock runs until it has been seen. `core_sleep_o` asserts when every domain is gated. Sits at the core top level in place of the single-gate sleep unit, feeding core, LSU and optional coprocessor clock domains.

---
 rtl/cve2_sleep_ctrl.sv | 132 +++++++++++++
 tb/tb_cve2_sleep_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_sleep_ctrl.sv
// Multi-domain sleep controller: per-domain idle hysteresis FSMs driving latch-based clock gates
// from one free-running clock, with a sticky fetch enable that gates all domains until seen.

module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Transparent only while the clock is low, so enable changes never shorten a high phase.
  always_latch begin
    if (!clk_i) begin
      en_latch = en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & en_latch;

endmodule

module cve2_sleep_ctrl #(
  parameter int NumDomains = 2,
  parameter int IdleHold   = 4
) (
  input  logic                  clk_ungated_i,
  input  logic                  rst_i,
  input  logic                  scan_cg_en_i,
  input  logic                  fetch_enable_i,
  output logic                  fetch_enable_o,
  input  logic [NumDomains-1:0] busy_i,
  input  logic [NumDomains-1:0] wake_i,
  input  logic [NumDomains-1:0] force_on_i,
  output logic [NumDomains-1:0] clk_gated_o,
  output logic [NumDomains-1:0] clk_en_o,
  output logic                  core_sleep_o
);

  localparam int CntW = (IdleHold > 0) ? $clog2(IdleHold + 1) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'((IdleHold > 0) ? (IdleHold - 1) : 0);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_SLEEP = 2'd3;

  logic                  fetch_enable_q;
  logic [NumDomains-1:0] busy_q;

  always_ff @(posedge clk_ungated_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_enable_q <= 1'b0;
      busy_q         <= '0;
    end else begin
      fetch_enable_q <= fetch_enable_i | fetch_enable_q;
      busy_q         <= busy_i;
    end
  end

  assign fetch_enable_o = fetch_enable_q;

  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            act;
    logic            en;

    assign act = busy_q[i] | wake_i[i] | force_on_i[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en      = 1'b0;
      case (state_q)
        ST_INIT: begin
          if (fetch_enable_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          en = 1'b1;
          if (!act) begin
            if (IdleHold > 0) begin
              state_d = ST_HOLD;
              cnt_d   = HoldLoad;
            end else begin
              state_d = ST_SLEEP;
            end
          end
        end
        ST_HOLD: begin
          en = 1'b1;
          if (act) begin
            state_d = ST_RUN;
          end else if (cnt_q == '0) begin
            state_d = ST_SLEEP;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        ST_SLEEP: begin
          // Wake sources open the gate in the same cycle they arrive.
          en = act;
          if (act) state_d = ST_RUN;
        end
        default: state_d = ST_INIT;
      endcase
    end

    always_ff @(posedge clk_ungated_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_INIT;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign clk_en_o[i] = en;

    cve2_clock_gate u_clock_gate (
      .clk_i     (clk_ungated_i),
      .en_i      (en),
      .test_en_i (scan_cg_en_i),
      .clk_o     (clk_gated_o[i])
    );
  end

  assign core_sleep_o = fetch_enable_q & ~|clk_en_o;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Bench for cve2_sleep_ctrl: two builds (IdleHold 4 and 0) driven in parallel and checked
// against an idle-streak reference model.

module tb_cve2_sleep_ctrl;

  localparam int IH_A = 4;
  localparam int IH_B = 0;

  logic       clk;
  logic       rst;
  logic       scan_en;
  logic       fetch_en;
  logic [1:0] busy, wake, force_on;
  logic       fe_a, fe_b, cs_a, cs_b;
  logic [1:0] cg_a, cg_b, en_a, en_b;

  cve2_sleep_ctrl #(.NumDomains(2), .IdleHold(IH_A)) dut_a (
    .clk_ungated_i (clk),      .rst_i        (rst),
    .scan_cg_en_i  (scan_en),  .fetch_enable_i (fetch_en),
    .fetch_enable_o(fe_a),     .busy_i       (busy),
    .wake_i        (wake),     .force_on_i   (force_on),
    .clk_gated_o   (cg_a),     .clk_en_o     (en_a),
    .core_sleep_o  (cs_a)
  );

  cve2_sleep_ctrl #(.NumDomains(2), .IdleHold(IH_B)) dut_b (
    .clk_ungated_i (clk),      .rst_i        (rst),
    .scan_cg_en_i  (scan_en),  .fetch_enable_i (fetch_en),
    .fetch_enable_o(fe_b),     .busy_i       (busy),
    .wake_i        (wake),     .force_on_i   (force_on),
    .clk_gated_o   (cg_b),     .clk_en_o     (en_b),
    .core_sleep_o  (cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a domain sleeps after IdleHold+1 consecutive idle awake cycles,
  // and wakes on the first active cycle while asleep.
  logic       m_fe_q;
  logic [1:0] m_bq;
  logic       m_started [2][2];
  logic       m_asleep  [2][2];
  int         m_streak  [2][2];

  function automatic int hold_of(int k);
    return (k == 0) ? IH_A : IH_B;
  endfunction

  task automatic model_reset();
    m_fe_q = 1'b0;
    m_bq   = 2'b00;
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 2; d++) begin
        m_started[k][d] = 1'b0;
        m_asleep[k][d]  = 1'b0;
        m_streak[k][d]  = 0;
      end
  endtask

  function automatic logic [1:0] exp_en(int k);
    logic [1:0] e;
    for (int d = 0; d < 2; d++) begin
      logic a;
      a = m_bq[d] | wake[d] | force_on[d];
      if (!m_started[k][d])     e[d] = 1'b0;
      else if (m_asleep[k][d])  e[d] = a;
      else                      e[d] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [1:0] ea, eb;
    ea = exp_en(0);
    eb = exp_en(1);
    return {m_fe_q, m_fe_q, m_fe_q & ~|ea, m_fe_q & ~|eb, ea, eb};
  endfunction

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 2; d++) begin
        logic a;
        a = m_bq[d] | wake[d] | force_on[d];
        if (!m_started[k][d]) begin
          m_started[k][d] = m_fe_q;
          m_streak[k][d]  = 0;
        end else if (m_asleep[k][d]) begin
          if (a) begin
            m_asleep[k][d] = 1'b0;
            m_streak[k][d] = 0;
          end
        end else begin
          m_streak[k][d] = a ? 0 : m_streak[k][d] + 1;
          if (m_streak[k][d] == hold_of(k) + 1) begin
            m_asleep[k][d] = 1'b1;
            m_streak[k][d] = 0;
          end
        end
      end
    m_fe_q = m_fe_q | fetch_en;
    m_bq   = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Gated clocks may only rise with the ungated clock high and fall with it low.
  logic [3:0] prev_g = 4'b0000;
  logic [3:0] now_g;
  int glitches = 0;
  always @(cg_a or cg_b) begin
    now_g = {cg_b, cg_a};
    for (int j = 0; j < 4; j++) begin
      if (!prev_g[j] && now_g[j] && !clk) glitches++;
      if (prev_g[j] && !now_g[j] && clk)  glitches++;
    end
    prev_g = now_g;
  end

  int edges0 = 0;
  int edges1 = 0;
  always @(posedge cg_a[0]) edges0++;
  always @(posedge cg_a[1]) edges1++;

  task automatic test_reset();
    #3;
    n_total++;
    if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== 8'h00)
      $display("FAIL reset_hold got=%b required=%b", {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, 8'h00);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL reset_idle c=%0d got=%b required=%b", c, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_fetch_enable();
    fetch_en = 1'b1;
    busy     = 2'b11;
    tick();
    fetch_en = 1'b0;
    #3;
    n_total++;
    if (fe_a !== 1'b1 || en_a !== 2'b00)
      $display("FAIL fetch_t1 got fe=%b en=%b required fe=1 en=00", fe_a, en_a);
    else n_pass++;
    tick();
    #3;
    n_total++;
    if (en_a !== 2'b11 || en_b !== 2'b11)
      $display("FAIL fetch_t2 got en_a=%b en_b=%b required 11 11", en_a, en_b);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL fetch_run c=%0d got=%b required=%b", c, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
      #3;
    end
    tick();
  endtask

  task automatic test_idle_hold();
    busy = 2'b10;
    for (int k = 0; k < 10; k++) begin
      #3;
      n_total++;
      if (en_a[0] !== (k <= IH_A + 1) || en_b[0] !== (k <= IH_B + 1) || cs_a !== 1'b0)
        $display("FAIL idle_hold k=%0d got a0=%b b0=%b cs=%b required a0=%b b0=%b cs=0",
                 k, en_a[0], en_b[0], cs_a, (k <= IH_A + 1), (k <= IH_B + 1));
      else n_pass++;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL idle_model k=%0d got=%b required=%b", k, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
    busy = 2'b00;
    for (int k = 0; k < 8; k++) begin
      #3;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL idle_both k=%0d got=%b required=%b", k, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
    #3;
    n_total++;
    if (cs_a !== 1'b1 || cs_b !== 1'b1)
      $display("FAIL core_sleep got a=%b b=%b required 1 1", cs_a, cs_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_wake();
    int e0;
    wake = 2'b01;
    #3;
    n_total++;
    if (en_a[0] !== 1'b1 || en_b[0] !== 1'b1 || cs_a !== 1'b0)
      $display("FAIL wake_now got a0=%b b0=%b cs=%b required 1 1 0", en_a[0], en_b[0], cs_a);
    else n_pass++;
    e0 = edges0;
    tick();
    wake = 2'b00;
    n_total++;
    if (edges0 !== e0 + 1)
      $display("FAIL wake_edge got=%0d required=%0d", edges0 - e0, 1);
    else n_pass++;
    for (int k = 1; k < 9; k++) begin
      #3;
      n_total++;
      if (en_a[0] !== (k <= IH_A + 1))
        $display("FAIL wake_rehold k=%0d got=%b required=%b", k, en_a[0], (k <= IH_A + 1));
      else n_pass++;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL wake_model k=%0d got=%b required=%b", k, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_hold_abort();
    busy = 2'b10;
    for (int c = 0; c < 4; c++) tick();
    for (int k = 0; k < 13; k++) begin
      busy = (k == 3) ? 2'b10 : 2'b00;
      #3;
      n_total++;
      if (en_a[1] !== (k <= 9))
        $display("FAIL hold_abort k=%0d got=%b required=%b", k, en_a[1], (k <= 9));
      else n_pass++;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL abort_model k=%0d got=%b required=%b", k, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_force_on();
    force_on = 2'b01;
    for (int c = 0; c < 100; c++) begin
      #3;
      n_total++;
      if (en_a[0] !== 1'b1 || en_b[0] !== 1'b1 || cs_a !== 1'b0 || cs_b !== 1'b0)
        $display("FAIL force_on c=%0d got a0=%b b0=%b cs=%b%b required 1 1 00", c, en_a[0], en_b[0], cs_a, cs_b);
      else n_pass++;
      tick();
    end
    force_on = 2'b00;
    for (int k = 0; k < 8; k++) begin
      #3;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL force_release k=%0d got=%b required=%b", k, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      busy     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0)};
      wake     = {($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0)};
      force_on = {($urandom_range(0, 31) == 0), ($urandom_range(0, 40) == 0)};
      fetch_en = ($urandom_range(0, 3) == 0);
      #3;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec())
        $display("FAIL random c=%0d got=%b required=%b", c, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
    busy = 2'b00; wake = 2'b00; force_on = 2'b00; fetch_en = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_reset_mid_hold();
    int e0, e1;
    busy = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    busy = 2'b00;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (en_a !== 2'b00 || en_b !== 2'b00 || fe_a !== 1'b0 || cs_a !== 1'b0)
      $display("FAIL reset_async got en_a=%b en_b=%b fe=%b cs=%b required 00 00 0 0", en_a, en_b, fe_a, cs_a);
    else n_pass++;
    scan_en = 1'b1;
    e0 = edges0;
    e1 = edges1;
    for (int c = 0; c < 3; c++) tick();
    n_total++;
    if (edges0 !== e0 + 3 || edges1 !== e1 + 3 || en_a !== 2'b00)
      $display("FAIL scan_toggle got edges=%0d,%0d en=%b required 3,3 en=00", edges0 - e0, edges1 - e1, en_a);
    else n_pass++;
    scan_en = 1'b0;
    tick();
    e0 = edges0;
    for (int c = 0; c < 3; c++) tick();
    n_total++;
    if (edges0 !== e0)
      $display("FAIL gated_in_reset got edges=%0d required=0", edges0 - e0);
    else n_pass++;
    rst  = 1'b0;
    busy = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #3;
      n_total++;
      if ({fe_a, fe_b, cs_a, cs_b, en_a, en_b} !== exp_vec() || fe_a !== 1'b0)
        $display("FAIL post_reset c=%0d got=%b required=%b", c, {fe_a, fe_b, cs_a, cs_b, en_a, en_b}, exp_vec());
      else n_pass++;
      tick();
    end
    n_total++;
    if (glitches !== 0)
      $display("FAIL glitch got=%0d required=0", glitches);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; fetch_en = 1'b0;
    busy = 2'b00; wake = 2'b00; force_on = 2'b00;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_fetch_enable();
    test_idle_hold();
    test_wake();
    test_hold_abort();
    test_force_on();
    test_random();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
